fft_stage_sequencer: RTL and testbench

Control sequencer for the radix-2 in-place FFT datapath.
- On a start pulse, walks every stage (0..N_LOG2-1) and every butterfly (0..N/2-1) within each stage.
- For each butterfly it presents the operand addresses, twiddle address, and raw stage/butterfly counters (the raw counters feed index_mapper) to the butterfly unit over a valid/ready handshake.
- Inserts a programmable drain gap between stages so in-flight write-backs retire before the next stage reads.

---
 rtl/fft_stage_sequencer.sv | 167 ++++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
// rtl/fft_stage_sequencer.sv - stage/butterfly command sequencer for a radix-2 in-place FFT
//
// Purpose:
//   On a start pulse, walks every stage (0..N_LOG2-1) and every butterfly
//   (0..N/2-1) within each stage. For each butterfly it issues one command
//   to the butterfly unit over a valid/ready handshake. A command carries the
//   operand addresses, the twiddle address and the raw stage/butterfly
//   counters. A programmable idle gap separates stages so write-backs that
//   are still in flight retire before the next stage reads.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   synchronous active-high reset, highest priority
//   start         in   begin a full pass (honoured only in IDLE)
//   out_ready     in   butterfly unit accepts the current command
//   out_valid     out  command fields valid
//   stage         out  current stage index (raw counter)
//   bfly          out  butterfly index within the stage (raw counter)
//   addr_a        out  upper-wing operand address
//   addr_b        out  lower-wing operand address
//   tw_addr       out  twiddle ROM address
//   last_in_stage out  final butterfly of the current stage
//   busy          out  high in every state except IDLE
//   done          out  one-cycle pulse at the end of the pass
module fft_stage_sequencer #(
  parameter int N_LOG2       = 4,
  parameter int STAGE_W      = 2,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [STAGE_W-1:0] stage,
  output logic [N_LOG2-2:0]  bfly,
  output logic [N_LOG2-1:0]  addr_a,
  output logic [N_LOG2-1:0]  addr_b,
  output logic [N_LOG2-2:0]  tw_addr,
  output logic               last_in_stage,
  output logic               busy,
  output logic               done
);

  localparam int BW = N_LOG2 - 1;
  localparam logic [BW-1:0]      BFLY_LAST  = {BW{1'b1}};
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(N_LOG2 - 1);
  // The counter is loaded on entry to DRAIN and DRAIN is left when it reads
  // zero, so the load value is one less than the number of gap cycles.
  localparam logic [3:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? 4'(DRAIN_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [BW-1:0]      bfly_q, bfly_d;
  logic [3:0]         drain_q, drain_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      bfly_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      bfly_q  <= bfly_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    bfly_d  = bfly_q;
    drain_d = drain_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          stage_d = '0;
          bfly_d  = '0;
        end
      end
      S_RUN: begin
        // out_valid is always high here, so out_ready alone marks a transfer.
        if (out_ready) begin
          if (bfly_q != BFLY_LAST) begin
            bfly_d = bfly_q + BW'(1);
          end else begin
            bfly_d = '0;
            if (stage_q == LAST_STAGE) begin
              state_d = S_DONE;
              stage_d = '0;
            end else if (DRAIN_CYCLES == 0) begin
              stage_d = stage_q + STAGE_W'(1);
            end else begin
              state_d = S_DRAIN;
              drain_d = DRAIN_LOAD;
            end
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == 4'd0) begin
          state_d = S_RUN;
          stage_d = stage_q + STAGE_W'(1);
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        stage_d = '0;
        bfly_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Address generation from the registered counters (s = stage, b = bfly,
  // M = 2^s): the butterfly index is split at bit s and a zero is inserted
  // there, giving the upper wing; the lower wing sits M above it.
  logic              run;
  logic [N_LOG2-1:0] b_ext;
  logic [N_LOG2-1:0] m_span;
  logic [N_LOG2-1:0] b_low;
  logic [N_LOG2-1:0] a_full;
  logic [N_LOG2-1:0] tw_full;
  logic [STAGE_W:0]  s_plus1;
  logic [STAGE_W-1:0] tw_shift;

  always_comb begin
    run      = (state_q == S_RUN);
    b_ext    = {1'b0, bfly_q};
    m_span   = N_LOG2'(1) << stage_q;
    b_low    = b_ext & (m_span - N_LOG2'(1));
    s_plus1  = {1'b0, stage_q} + (STAGE_W + 1)'(1);
    a_full   = ((b_ext >> stage_q) << s_plus1) | b_low;
    // b_low < 2^s, so shifting by (N_LOG2-1-s) always fits in N_LOG2-1 bits.
    tw_shift = LAST_STAGE - stage_q;
    tw_full  = b_low << tw_shift;
  end

  // Command fields read zero whenever no command is offered, so IDLE,
  // DRAIN and DONE present an all-zero bus.
  always_comb begin
    out_valid     = run;
    stage         = run ? stage_q : '0;
    bfly          = run ? bfly_q : '0;
    addr_a        = run ? a_full : '0;
    addr_b        = run ? (a_full + m_span) : '0;
    tw_addr       = run ? tw_full[BW-1:0] : '0;
    last_in_stage = run && (bfly_q == BFLY_LAST);
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb/tb_fft_stage_sequencer.sv - directed self-checking bench for fft_stage_sequencer
module tb_fft_stage_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Default configuration: N_LOG2=4, STAGE_W=2, DRAIN_CYCLES=2
  logic       start0, rdy0;
  logic       valid0, last0, busy0, done0;
  logic [1:0] stage0;
  logic [2:0] bfly0, tw0;
  logic [3:0] aa0, ab0;

  // Small configuration: N_LOG2=3, STAGE_W=2, DRAIN_CYCLES=0
  logic       start1, rdy1;
  logic       valid1, last1, busy1, done1;
  logic [1:0] stage1, bfly1, tw1;
  logic [2:0] aa1, ab1;

  fft_stage_sequencer #(.N_LOG2(4), .STAGE_W(2), .DRAIN_CYCLES(2)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .out_ready(rdy0),
    .out_valid(valid0), .stage(stage0), .bfly(bfly0), .addr_a(aa0), .addr_b(ab0),
    .tw_addr(tw0), .last_in_stage(last0), .busy(busy0), .done(done0)
  );

  fft_stage_sequencer #(.N_LOG2(3), .STAGE_W(2), .DRAIN_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .out_ready(rdy1),
    .out_valid(valid1), .stage(stage1), .bfly(bfly1), .addr_a(aa1), .addr_b(ab1),
    .tw_addr(tw1), .last_in_stage(last1), .busy(busy1), .done(done1)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed address vectors for the default configuration:
  // cycle in pass, expected addr_a, addr_b, tw_addr.
  int ac [4] = '{4, 14, 27, 36};
  int ea [4] = '{6, 5, 10, 5};
  int eb [4] = '{7, 7, 14, 13};
  int et [4] = '{0, 4, 4, 5};

  initial begin
    int xfers;
    int done_at;
    int done_cnt;
    logic ev;

    reset  = 1'b1;
    start0 = 1'b0;
    rdy0   = 1'b1;
    start1 = 1'b0;
    rdy1   = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_valid", valid0, 0);
    chk("rst_stage", stage0, 0);
    chk("rst_bfly", bfly0, 0);
    chk("rst_addr_a", aa0, 0);
    chk("rst_addr_b", ab0, 0);
    chk("rst_tw", tw0, 0);
    chk("rst_last", last0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_valid_small", valid1, 0);
    reset = 1'b0;

    // Full pass, out_ready held high; start pulsed in cycle 0
    start0 = 1'b1;
    xfers  = 0;
    for (int c = 1; c <= 39; c++) begin
      tick();
      start0 = 1'b0;
      ev = (c <= 38) && (((c - 1) % 10) < 8);
      chk("t1_valid", valid0, ev);
      chk("t1_done", done0, (c == 39));
      chk("t1_busy", busy0, 1);
      if (ev) begin
        chk("t1_stage", stage0, (c - 1) / 10);
        chk("t1_bfly", bfly0, (c - 1) % 10);
        chk("t1_last", last0, (((c - 1) % 10) == 7));
      end
      if (valid0 && rdy0) xfers++;
      for (int k = 0; k < 4; k++) begin
        if (c == ac[k]) begin
          chk("t2_addr_a", aa0, ea[k]);
          chk("t2_addr_b", ab0, eb[k]);
          chk("t2_tw", tw0, et[k]);
        end
      end
    end
    chk("t1_transfers", xfers, 32);
    tick();
    chk("t1_idle_busy", busy0, 0);
    chk("t1_idle_done", done0, 0);

    // Backpressure for 5 cycles at stage 1, butterfly 2 (cycle 13)
    start0  = 1'b1;
    done_at = -1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      start0 = 1'b0;
      if (c >= 13 && c <= 18) begin
        chk("t3_hold_valid", valid0, 1);
        chk("t3_hold_stage", stage0, 1);
        chk("t3_hold_bfly", bfly0, 2);
        chk("t3_hold_addr_a", aa0, 4);
        chk("t3_hold_addr_b", ab0, 6);
        chk("t3_hold_tw", tw0, 0);
      end
      if (c == 19) chk("t3_next_bfly", bfly0, 3);
      rdy0 = !(c >= 13 && c <= 17);
      if (done0) begin
        done_at = c;
        break;
      end
    end
    chk("t3_done_cycle", done_at, 44);
    rdy0 = 1'b1;
    tick();

    // Reset mid-pass at stage 2, butterfly 4 (cycle 25)
    start0 = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      tick();
      start0 = (c == 5);
    end
    chk("t4_pre_stage", stage0, 2);
    chk("t4_pre_bfly", bfly0, 4);
    reset = 1'b1;
    tick();
    chk("t4_rst_valid", valid0, 0);
    chk("t4_rst_stage", stage0, 0);
    chk("t4_rst_bfly", bfly0, 0);
    chk("t4_rst_addr_b", ab0, 0);
    chk("t4_rst_busy", busy0, 0);
    chk("t4_rst_done", done0, 0);
    reset  = 1'b0;
    start0 = 1'b1;

    // Fresh pass after reset; start also pulsed during RUN and in DONE
    done_cnt = 0;
    for (int c = 1; c <= 39; c++) begin
      tick();
      start0 = (c == 5) || (c == 39);
      if (c == 1) begin
        chk("t4_first_valid", valid0, 1);
        chk("t4_first_stage", stage0, 0);
        chk("t4_first_bfly", bfly0, 0);
      end
      chk("t5_done", done0, (c == 39));
      if (done0) done_cnt++;
    end
    for (int c = 40; c <= 55; c++) begin
      tick();
      start0 = 1'b0;
      chk("t5_no_rerun_valid", valid0, 0);
      chk("t5_no_rerun_busy", busy0, 0);
      if (done0) done_cnt++;
    end
    chk("t5_done_pulses", done_cnt, 1);

    // DRAIN_CYCLES=0, N_LOG2=3: 12 back-to-back commands, done in cycle 13
    start1 = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      tick();
      start1 = 1'b0;
      chk("t6_valid", valid1, (c <= 12));
      chk("t6_done", done1, (c == 13));
      if (c <= 12) begin
        chk("t6_stage", stage1, (c - 1) / 4);
        chk("t6_bfly", bfly1, (c - 1) % 4);
      end
    end
    tick();
    chk("t6_idle_busy", busy1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
